// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the CPU and the loader/debug port, one
// transaction at a time, hiding the read latency behind a req/ack handshake.
module mem_port_arbiter #(
  parameter int AW     = 12,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_run,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_ack,
  output logic [DW-1:0] ldr_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          o_busy
);
  // state | meaning
  // IDLE  | no transaction; the only state where arbitration happens
  // ISSUE | single-cycle mem_en strobe for the granted transaction
  // WAIT  | read latency down-count; captures mem_rdata at terminal count
  // DONE  | owner's ack pulse; always returns to IDLE
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam int CW = 2;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;       // 1 = loader owns the transaction
  logic          last_ldr_q, last_ldr_d;
  logic          we_q, we_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_en_d, mem_we_d, cpu_ack_d, ldr_ack_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d, cpu_rdata_d, ldr_rdata_d;
  logic          grant_ldr;

  // Halted: loader always wins a tie. Running: the port not served last wins.
  assign grant_ldr = ldr_req && (!cpu_req || !i_run || !last_ldr_q);
  assign o_busy    = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_ldr_d  = last_ldr_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    cpu_ack_d   = 1'b0;
    ldr_ack_d   = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    cpu_rdata_d = cpu_rdata;
    ldr_rdata_d = ldr_rdata;
    case (state_q)
      IDLE: begin
        if (cpu_req || ldr_req) begin
          owner_d     = grant_ldr;
          last_ldr_d  = grant_ldr;
          we_d        = grant_ldr ? ldr_we : cpu_we;
          mem_addr_d  = grant_ldr ? ldr_addr : cpu_addr;
          mem_wdata_d = grant_ldr ? ldr_wdata : cpu_wdata;
          mem_en_d    = 1'b1;
          mem_we_d    = grant_ldr ? ldr_we : cpu_we;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          cpu_ack_d = !owner_q;
          ldr_ack_d = owner_q;
          state_d   = DONE;
        end else begin
          cnt_d   = CW'(RD_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (owner_q) ldr_rdata_d = mem_rdata;
          else         cpu_rdata_d = mem_rdata;
          cpu_ack_d = !owner_q;
          ldr_ack_d = owner_q;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_ldr_q <= 1'b1;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      cpu_ack    <= 1'b0;
      ldr_ack    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      ldr_rdata  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_ldr_q <= last_ldr_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      mem_en     <= mem_en_d;
      mem_we     <= mem_we_d;
      cpu_ack    <= cpu_ack_d;
      ldr_ack    <= ldr_ack_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      cpu_rdata  <= cpu_rdata_d;
      ldr_rdata  <= ldr_rdata_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (RD_LAT 1 and 4) driven in turn
// and compared each cycle against a transaction-schedule reference model.
module tb_mem_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 16;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n [2], i_run [2];
  logic          cpu_req [2], cpu_we [2], ldr_req [2], ldr_we [2];
  logic [AW-1:0] cpu_addr [2], ldr_addr [2], mem_addr [2];
  logic [DW-1:0] cpu_wdata [2], ldr_wdata [2], cpu_rdata [2], ldr_rdata [2];
  logic [DW-1:0] mem_wdata [2], mem_rdata [2];
  logic          cpu_ack [2], ldr_ack [2], mem_en [2], mem_we [2], o_busy [2];

  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 'h010) return 16'hA5C3;
    return 16'(a * 40503) ^ 16'h5A5A;
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 4;
    logic [DW-1:0] marr [4096];
    logic [DW-1:0] dl [LAT];
    bit init_done = 1'b0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT)) u_dut (
      .clk(clk), .reset_n(reset_n[g]), .i_run(i_run[g]),
      .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]),
      .cpu_wdata(cpu_wdata[g]), .cpu_ack(cpu_ack[g]), .cpu_rdata(cpu_rdata[g]),
      .ldr_req(ldr_req[g]), .ldr_we(ldr_we[g]), .ldr_addr(ldr_addr[g]),
      .ldr_wdata(ldr_wdata[g]), .ldr_ack(ldr_ack[g]), .ldr_rdata(ldr_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .o_busy(o_busy[g])
    );

    // Memory macro: read data appears LAT cycles after the strobe, junk otherwise.
    always @(posedge clk) begin
      if (!init_done) begin
        for (int i = 0; i < 4096; i++) marr[i] <= init_val(i);
        init_done <= 1'b1;
      end else if (mem_en[g] && mem_we[g]) begin
        marr[mem_addr[g]] <= mem_wdata[g];
      end
      dl[0] <= (mem_en[g] && !mem_we[g]) ? marr[mem_addr[g]] : 16'($urandom);
      for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
    end
    assign mem_rdata[g] = dl[LAT-1];
  end

  // Reference model: pending requests per port and the schedule of the
  // transaction in flight (grant cycle, IDLE-to-IDLE duration).
  int            n_vec, n_err;
  int            cyc [2];
  bit            act [2], ack_now [2], t_own [2], t_we [2], last_ldr [2];
  int            t_start [2], t_dur [2];
  logic [AW-1:0] t_addr [2];
  logic [DW-1:0] t_wdata [2], t_rval [2];
  logic [DW-1:0] exp_rd [2][2];
  bit            p_v [2][2], p_we [2][2];
  logic [AW-1:0] p_addr [2][2];
  logic [DW-1:0] p_wd [2][2];
  logic [DW-1:0] ref_mem [2][4096];
  bit            rnd_mode;
  int            req_pct;
  int            obs_order [$];

  task automatic check_val(input int k, input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL u%0d %s: got 0x%0h want 0x%0h at cycle %0d", k, tag, obs, exp, cyc[k]);
    end
  endtask

  task automatic drive(input int k);
    cpu_req[k] = p_v[k][0]; cpu_we[k] = p_we[k][0];
    cpu_addr[k] = p_addr[k][0]; cpu_wdata[k] = p_wd[k][0];
    ldr_req[k] = p_v[k][1]; ldr_we[k] = p_we[k][1];
    ldr_addr[k] = p_addr[k][1]; ldr_wdata[k] = p_wd[k][1];
  endtask

  task automatic post(input int k, input int p, input bit we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    p_v[k][p] = 1'b1; p_we[k][p] = we; p_addr[k][p] = a; p_wd[k][p] = d;
  endtask

  task automatic post_rand(input int k, input int p, input bit keep_we);
    bit we;
    we = keep_we ? p_we[k][p] : 1'($urandom_range(1));
    post(k, p, we, ($urandom_range(1) == 1) ? 12'($urandom_range(15)) : 12'($urandom_range(4095)),
         16'($urandom));
  endtask

  task automatic tick(input int k);
    bit en_e;
    @(negedge clk);
    cyc[k]++;
    en_e       = act[k] && (cyc[k] == t_start[k] + 1);
    ack_now[k] = act[k] && (cyc[k] == t_start[k] + t_dur[k] - 1);
    if (ack_now[k] && !t_we[k]) exp_rd[k][t_own[k]] = t_rval[k];
    check_val(k, "mem_en", 32'(mem_en[k]), 32'(en_e));
    check_val(k, "mem_we", 32'(mem_we[k]), 32'(en_e && t_we[k]));
    check_val(k, "o_busy", 32'(o_busy[k]), 32'(act[k] && cyc[k] > t_start[k]));
    check_val(k, "cpu_ack", 32'(cpu_ack[k]), 32'(ack_now[k] && !t_own[k]));
    check_val(k, "ldr_ack", 32'(ldr_ack[k]), 32'(ack_now[k] && t_own[k]));
    check_val(k, "cpu_rdata", 32'(cpu_rdata[k]), 32'(exp_rd[k][0]));
    check_val(k, "ldr_rdata", 32'(ldr_rdata[k]), 32'(exp_rd[k][1]));
    if (en_e) begin
      check_val(k, "mem_addr", 32'(mem_addr[k]), 32'(t_addr[k]));
      if (t_we[k]) check_val(k, "mem_wdata", 32'(mem_wdata[k]), 32'(t_wdata[k]));
    end
    if (ack_now[k]) p_v[k][t_own[k]] = 1'b0;
  endtask

  task automatic grant(input int k);
    int o;
    if (p_v[k][0] && p_v[k][1]) o = (i_run[k] && last_ldr[k]) ? 0 : 1;
    else                        o = p_v[k][1] ? 1 : 0;
    act[k]     = 1'b1;
    t_start[k] = cyc[k];
    t_own[k]   = (o == 1);
    t_we[k]    = p_we[k][o];
    t_addr[k]  = p_addr[k][o];
    t_wdata[k] = p_wd[k][o];
    t_dur[k]   = t_we[k] ? 3 : lat(k) + 3;
    if (t_we[k]) ref_mem[k][t_addr[k]] = t_wdata[k];
    else         t_rval[k] = ref_mem[k][t_addr[k]];
    last_ldr[k] = (o == 1);
  endtask

  task automatic finish(input int k);
    if (rnd_mode) begin
      if ($urandom_range(49) == 0) i_run[k] = ~i_run[k];
      for (int p = 0; p < 2; p++) begin
        if (!p_v[k][p]) begin
          if ($urandom_range(99) < req_pct) post_rand(k, p, 1'b0);
        end else if ($urandom_range(3) == 0) begin
          // once granted, the requester may still wiggle addr/wdata; we stays put
          post_rand(k, p, act[k] && (int'(t_own[k]) == p));
        end
      end
    end
    drive(k);
    if (reset_n[k] && !act[k] && (p_v[k][0] || p_v[k][1])) grant(k);
    if (ack_now[k]) act[k] = 1'b0;
  endtask

  task automatic run(input int k, input int n);
    repeat (n) begin tick(k); finish(k); end
  endtask

  task automatic run_log(input int k, input int n, input bit keep_busy);
    repeat (n) begin
      tick(k);
      if (cpu_ack[k]) obs_order.push_back(0);
      if (ldr_ack[k]) obs_order.push_back(1);
      if (keep_busy) for (int p = 0; p < 2; p++) if (!p_v[k][p]) post_rand(k, p, 1'b0);
      finish(k);
    end
  endtask

  task automatic model_reset(input int k);
    act[k] = 1'b0; ack_now[k] = 1'b0; last_ldr[k] = 1'b1;
    exp_rd[k][0] = '0; exp_rd[k][1] = '0;
    p_v[k][0] = 1'b0; p_v[k][1] = 1'b0;
    drive(k);
  endtask

  task automatic release_reset(input int k);
    tick(k);
    reset_n[k] = 1'b1;
    finish(k);
  endtask

  initial begin
    n_vec = 0; n_err = 0; rnd_mode = 1'b0; req_pct = 30;
    for (int k = 0; k < 2; k++) begin
      reset_n[k] = 1'b0; i_run[k] = 1'b1; cyc[k] = 0;
      for (int p = 0; p < 2; p++) begin
        p_we[k][p] = 1'b0; p_addr[k][p] = '0; p_wd[k][p] = '0;
      end
      for (int i = 0; i < 4096; i++) ref_mem[k][i] = init_val(i);
      model_reset(k);
    end

    // reset, then idle
    run(0, 2);
    check_val(0, "rst_mem_addr", 32'(mem_addr[0]), 32'h0);
    check_val(0, "rst_mem_wdata", 32'(mem_wdata[0]), 32'h0);
    release_reset(0);
    run(0, 5);

    // single CPU read of 0x010
    tick(0); post(0, 0, 1'b0, 12'h010, 16'h0); finish(0);
    run(0, 8);
    check_val(0, "cpu_rdata_hold", 32'(cpu_rdata[0]), 32'hA5C3);

    // loader write while halted
    i_run[0] = 1'b0;
    tick(0); post(0, 1, 1'b1, 12'h0FF, 16'h7001); finish(0);
    run(0, 6);

    // running, both ports hammering: grants must alternate starting with CPU
    i_run[0] = 1'b1;
    obs_order.delete();
    run_log(0, 40, 1'b1);
    run(0, 12);
    check_val(0, "alt_count_ge4", 32'(obs_order.size() >= 4), 32'h1);
    if (obs_order.size() >= 4)
      for (int i = 0; i < 4; i++) check_val(0, "alt_order", 32'(obs_order[i]), 32'(i % 2));

    // halted, simultaneous: loader first, CPU after loader's DONE
    i_run[0] = 1'b0;
    obs_order.delete();
    tick(0);
    post(0, 0, 1'b0, 12'h0AA, 16'h0);
    post(0, 1, 1'b0, 12'h0BB, 16'h0);
    finish(0);
    run_log(0, 12, 1'b0);
    check_val(0, "halt_count", 32'(obs_order.size()), 32'd2);
    if (obs_order.size() >= 1) check_val(0, "halt_first", 32'(obs_order[0]), 32'd1);

    // random traffic on RD_LAT=1
    rnd_mode = 1'b1;
    run(0, 3000);
    rnd_mode = 1'b0;

    // RD_LAT=4 instance: reset, contention during WAIT
    run(1, 2);
    release_reset(1);
    tick(1); post(1, 0, 1'b0, 12'h123, 16'h0); finish(1);
    run(1, 3);
    tick(1); post(1, 1, 1'b0, 12'h456, 16'h0); finish(1);
    run(1, 16);

    // reset in the middle of a read's WAIT phase
    tick(1); post(1, 0, 1'b0, 12'h0F0, 16'h0); finish(1);
    run(1, 3);
    reset_n[1] = 1'b0;
    model_reset(1);
    run(1, 8);
    release_reset(1);
    tick(1); post(1, 0, 1'b0, 12'h010, 16'h0); finish(1);
    run(1, 10);
    check_val(1, "post_rst_rdata", 32'(cpu_rdata[1]), 32'hA5C3);

    // random traffic on RD_LAT=4
    rnd_mode = 1'b1;
    run(1, 2000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
